// File: rtl/step_seq_gen_tmr_triplevoter_if.sv
// step_seq_gen_tmr_triplevoter_if: per-lane request/response bundle of the TMR step-sequence transmitter
// Signals: start/sel/step per lane (requests), data/busy/done per lane and sticky mismatch (responses).
// Modports: master drives requests and observes responses; slave is the transmitter side.
interface step_seq_gen_tmr_triplevoter_if #(
   parameter int IO_SIZE_G = 3
);
   logic                 start_a_i, start_b_i, start_c_i;
   logic                 sel_a_i, sel_b_i, sel_c_i;
   logic                 step_a_i, step_b_i, step_c_i;
   logic [IO_SIZE_G-1:0] data_a_o, data_b_o, data_c_o;
   logic                 busy_a_o, busy_b_o, busy_c_o;
   logic                 done_a_o, done_b_o, done_c_o;
   logic                 mismatch_o;
   modport master (
      output start_a_i, start_b_i, start_c_i, sel_a_i, sel_b_i, sel_c_i,
             step_a_i, step_b_i, step_c_i,
      input  data_a_o, data_b_o, data_c_o, busy_a_o, busy_b_o, busy_c_o,
             done_a_o, done_b_o, done_c_o, mismatch_o
   );
   modport slave (
      input  start_a_i, start_b_i, start_c_i, sel_a_i, sel_b_i, sel_c_i,
             step_a_i, step_b_i, step_c_i,
      output data_a_o, data_b_o, data_c_o, busy_a_o, busy_b_o, busy_c_o,
             done_a_o, done_b_o, done_c_o, mismatch_o
   );
endinterface

// File: rtl/step_seq_gen_tmr_triplevoter.sv
// step_seq_gen_tmr_triplevoter: triple-redundant transmitter of two 3-symbol step sequences
// Ports: clk_i clock; rst_i asynchronous active-high reset;
//   bus (slave) per lane x in {a,b,c}: start_x_i, sel_x_i (0=S1, 1=S2), step_x_i in;
//   data_x_o, busy_x_o, done_x_o out; mismatch_o sticky copy-disagreement flag.
module step_seq_gen_tmr_triplevoter #(
   parameter int                   IO_SIZE_G   = 3,
   parameter logic [IO_SIZE_G-1:0] IDLE_CODE_G = IO_SIZE_G'(0),
   parameter logic [IO_SIZE_G-1:0] S1_A_G      = IO_SIZE_G'(1),
   parameter logic [IO_SIZE_G-1:0] S1_B_G      = IO_SIZE_G'(2),
   parameter logic [IO_SIZE_G-1:0] S1_C_G      = IO_SIZE_G'(3),
   parameter logic [IO_SIZE_G-1:0] S2_A_G      = IO_SIZE_G'(4),
   parameter logic [IO_SIZE_G-1:0] S2_B_G      = IO_SIZE_G'(5),
   parameter logic [IO_SIZE_G-1:0] S2_C_G      = IO_SIZE_G'(6)
) (
   input logic                           clk_i,
   input logic                           rst_i,
   step_seq_gen_tmr_triplevoter_if.slave bus
);
   typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_SA, ST_SB, ST_SC, ST_END} state_t;
   // each copy is {state, latched sel}
   logic [3:0] cp_a_q, cp_b_q, cp_c_q;
   logic [3:0] vt_a, vt_b, vt_c, nx_a, nx_b, nx_c;
   logic       mis_q;
   function automatic logic [3:0] vote(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction
   // illegal encodings 5-7 fall back to IDLE with sel cleared
   function automatic logic [3:0] next_f(input logic [3:0] v, input logic start, input logic sel, input logic step);
      logic [2:0] st;
      st = v[3:1];
      return (st == ST_IDLE) ? (start ? {ST_SA, sel} : v)
           : (st == ST_END)  ? {ST_IDLE, v[0]}
           : (st >  ST_END)  ? {ST_IDLE, 1'b0}
           : step            ? {st + 3'd1, v[0]}
           :                   v;
   endfunction
   function automatic logic [IO_SIZE_G-1:0] data_f(input logic [3:0] v);
      logic [2:0] st;
      st = v[3:1];
      return (st == ST_SA) ? (v[0] ? S2_A_G : S1_A_G)
           : (st == ST_SB) ? (v[0] ? S2_B_G : S1_B_G)
           : (st == ST_SC) ? (v[0] ? S2_C_G : S1_C_G)
           :                 IDLE_CODE_G;
   endfunction
   function automatic logic busy_f(input logic [3:0] v);
      return (v[3:1] != ST_IDLE) && (v[3:1] <= ST_END);
   endfunction
   // three independent voters so no single voter is a common point of failure
   always_comb begin
      vt_a = vote(cp_a_q, cp_b_q, cp_c_q);
      vt_b = vote(cp_a_q, cp_b_q, cp_c_q);
      vt_c = vote(cp_a_q, cp_b_q, cp_c_q);
      nx_a = next_f(vt_a, bus.start_a_i, bus.sel_a_i, bus.step_a_i);
      nx_b = next_f(vt_b, bus.start_b_i, bus.sel_b_i, bus.step_b_i);
      nx_c = next_f(vt_c, bus.start_c_i, bus.sel_c_i, bus.step_c_i);
      bus.data_a_o = data_f(vt_a);
      bus.data_b_o = data_f(vt_b);
      bus.data_c_o = data_f(vt_c);
      bus.busy_a_o = busy_f(vt_a);
      bus.busy_b_o = busy_f(vt_b);
      bus.busy_c_o = busy_f(vt_c);
      bus.done_a_o = vt_a[3:1] == ST_END;
      bus.done_b_o = vt_b[3:1] == ST_END;
      bus.done_c_o = vt_c[3:1] == ST_END;
      bus.mismatch_o = mis_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cp_a_q <= {ST_IDLE, 1'b0};
         cp_b_q <= {ST_IDLE, 1'b0};
         cp_c_q <= {ST_IDLE, 1'b0};
         mis_q  <= 1'b0;
      end else begin
         cp_a_q <= nx_a;
         cp_b_q <= nx_b;
         cp_c_q <= nx_c;
         mis_q  <= mis_q | (cp_a_q != cp_b_q) | (cp_b_q != cp_c_q);
      end
   end
endmodule

// File: tb/tb_step_seq_gen_tmr_triplevoter.sv
// tb_step_seq_gen_tmr_triplevoter: directed self-checking bench for the TMR step-sequence transmitter
module tb_step_seq_gen_tmr_triplevoter;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   step_seq_gen_tmr_triplevoter_if #(.IO_SIZE_G(3)) bus ();
   step_seq_gen_tmr_triplevoter dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // packs all three lanes' data/busy/done plus mismatch into one word
   task automatic out(input string tag, input logic [2:0] d, input logic b, input logic dn, input logic ms);
      chk(tag,
          {16'd0, bus.data_a_o, bus.data_b_o, bus.data_c_o, bus.busy_a_o, bus.busy_b_o, bus.busy_c_o,
           bus.done_a_o, bus.done_b_o, bus.done_c_o, bus.mismatch_o},
          {16'd0, d, d, d, b, b, b, dn, dn, dn, ms});
   endtask
   task automatic drv(input logic st, input logic sl, input logic sp);
      bus.start_a_i = st; bus.start_b_i = st; bus.start_c_i = st;
      bus.sel_a_i   = sl; bus.sel_b_i   = sl; bus.sel_c_i   = sl;
      bus.step_a_i  = sp; bus.step_b_i  = sp; bus.step_c_i  = sp;
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b1;
      drv(0, 0, 0);
      @(negedge clk);
      out("reset", 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      repeat (10) tick();
      out("idle10", 0, 0, 0, 0);
      // sequence 1 with step held high
      drv(1, 0, 1);
      tick();
      drv(0, 0, 1);
      out("s1_a", 1, 1, 0, 0);
      tick(); out("s1_b", 2, 1, 0, 0);
      tick(); out("s1_c", 3, 1, 0, 0);
      tick(); out("s1_end", 0, 1, 1, 0);
      tick(); out("s1_idle", 0, 0, 0, 0);
      // sequence 2, step pattern 1,0,0,1,1 from SA, sel toggled mid-run
      drv(1, 1, 1);
      tick();
      drv(0, 0, 1);
      out("s2_a", 4, 1, 0, 0);
      tick(); out("s2_b", 5, 1, 0, 0);
      drv(0, 1, 0);
      tick(); out("s2_hold1", 5, 1, 0, 0);
      drv(0, 0, 0);
      tick(); out("s2_hold2", 5, 1, 0, 0);
      drv(0, 1, 1);
      tick(); out("s2_c", 6, 1, 0, 0);
      tick(); out("s2_end", 0, 1, 1, 0);
      tick(); out("s2_idle", 0, 0, 0, 0);
      // start held high through SB and END is ignored until IDLE
      drv(1, 0, 1);
      tick(); out("rs_a", 1, 1, 0, 0);
      tick(); out("rs_b", 2, 1, 0, 0);
      tick(); out("rs_c", 3, 1, 0, 0);
      tick(); out("rs_end", 0, 1, 1, 0);
      tick(); out("rs_idle", 0, 0, 0, 0);
      tick(); out("rs_restart", 1, 1, 0, 0);
      drv(0, 0, 1);
      tick(); out("rs2_b", 2, 1, 0, 0);
      tick(); out("rs2_c", 3, 1, 0, 0);
      tick(); out("rs2_end", 0, 1, 1, 0);
      tick(); out("rs2_idle", 0, 0, 0, 0);
      // single-copy upset on copy b during SB
      drv(1, 0, 1);
      tick();
      drv(0, 0, 1);
      tick(); out("up_pre", 2, 1, 0, 0);
      force dut.cp_b_q = 4'b1110;
      #1 out("up_sb", 2, 1, 0, 0);
      @(posedge clk);
      #1 release dut.cp_b_q;
      @(negedge clk);
      out("up_sc", 3, 1, 0, 1);
      tick(); out("up_end", 0, 1, 1, 1);
      chk("up_conv", {28'd0, dut.cp_b_q}, 32'h8);
      tick(); out("up_idle", 0, 0, 0, 1);
      repeat (3) tick();
      out("up_sticky", 0, 0, 0, 1);
      // asynchronous reset while in SC
      drv(1, 0, 1);
      tick();
      drv(0, 0, 1);
      tick();
      tick(); out("ar_sc", 3, 1, 0, 1);
      #2 rst = 1'b1;
      #1 out("ar_async", 0, 0, 0, 0);
      @(negedge clk);
      out("ar_hold", 0, 0, 0, 0);
      rst = 1'b0;
      repeat (4) tick();
      out("ar_after", 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/step_seq_gen_tmr_triplevoter.md
Name: step_seq_gen_tmr_triplevoter

Overview:
- Triple-modular-redundant sequence transmitter. Drives the two 3-symbol step sequences (S1, S2) onto three redundant data lanes, for consumption by the TMR step-sequence recogniser FSM.
- Every state bit is held in three registers (lanes a/b/c). Each lane has its own majority voter over all three copies, and each lane computes its next state from its own voted state and its own inputs.
- A sticky mismatch flag reports any disagreement between the three copies.

Parameters:
- IO_SIZE_G, 3, width of each data lane.
- IDLE_CODE_G, 0, symbol driven when no sequence is active.
- S1_A_G, 1; S1_B_G, 2; S1_C_G, 3: symbols of sequence 1, in order.
- S2_A_G, 4; S2_B_G, 5; S2_C_G, 6: symbols of sequence 2, in order.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_a_i, start_b_i, start_c_i  in  1 each  per-lane request to start a sequence
- sel_a_i, sel_b_i, sel_c_i  in  1 each  per-lane sequence select: 0 = S1, 1 = S2; sampled with start
- step_a_i, step_b_i, step_c_i  in  1 each  per-lane advance enable; 0 holds the current symbol
- data_a_o, data_b_o, data_c_o  out  IO_SIZE_G each  transmitted symbol per lane
- busy_a_o, busy_b_o, busy_c_o  out  1 each  per-lane: a sequence is in progress
- done_a_o, done_b_o, done_c_o  out  1 each  per-lane one-cycle completion pulse
- mismatch_o  out  1  sticky: redundant copies have disagreed

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Per-lane register: 3-bit state plus 1-bit latched sel. All three copies reset asynchronously to IDLE / sel=0.
- Voting: each lane uses its own bitwise 2-of-3 majority voter over all three {state, sel} copies. Lane x computes next state only from its own voted value and its own start/sel/step inputs.
- State encoding and transitions (voted state, lane x inputs):
  - IDLE (0): start=1 → SA and latch sel; otherwise stay.
  - SA (1), SB (2), SC (3): step=1 → advance SA→SB→SC→END; step=0 → hold. start is ignored.
  - END (4): unconditionally → IDLE after one cycle. start is ignored.
  - Voted encodings 5–7: → IDLE, latched sel forced to 0.
- Outputs are combinational from that lane's voted value:
  - data: IDLE or END → IDLE_CODE_G; SA/SB/SC → S1_A/B/C_G if latched sel=0, S2_A/B/C_G if latched sel=1.
  - busy = 1 in SA, SB, SC, END.
  - done = 1 only in END.
- Timing: start sampled in IDLE at edge k → symbol A visible after edge k. With step held at 1, B follows after k+1, C after k+2, END after k+3, IDLE after k+4. Each cycle with step=0 adds one cycle of hold.
- Sel changes after start are ignored until the next IDLE.
- Start asserted in the same cycle as END → ignored; a new start is accepted from IDLE only.
- Mismatch:
  - mismatch_o is registered. It sets at the first edge where the three {state, sel} copies are not all identical.
  - It stays set until rst_i; it has no other clear.
  - Reset value is 0.
- Single-copy upset: corrected within one cycle, because all three copies reload from voted next states. Outputs are unaffected. mismatch_o is set.
- Reset mid-sequence: all outputs go immediately (asynchronously) to data=IDLE_CODE_G, busy=0, done=0, mismatch=0. No END/done is generated.
- Reset values of all outputs: data_*_o = IDLE_CODE_G, busy_*_o = 0, done_*_o = 0, mismatch_o = 0.

Test Plan:
1. Reset, then idle for 10 cycles with start=0 → all data=0, busy=0, done=0, mismatch=0.
2. Pulse start=1, sel=0 on all lanes; step held 1 → data sequence 1,2,3,0 on all lanes. busy high for 4 cycles. done high only on the 0 (END) cycle. Back to IDLE next cycle.
3. start with sel=1; step pattern 1,0,0,1,1 starting in SA → data 4,5,5,5,6,0. sel toggled mid-sequence has no effect.
4. start re-asserted in SB and again in END → ignored. A single 1,2,3,0 run, then IDLE; a new start is accepted one cycle after END.
5. Force copy b of the state register to 7 during SB → all lanes still output 2 then 3. Copy b re-converges the next cycle. mismatch_o = 1 and stays 1 until reset.
6. Assert rst_i asynchronously while in SC (between clock edges) → data=0, busy=0 immediately. No done pulse. mismatch_o cleared.
